// File: rtl/gru_seq_ctrl.sv
// rtl/gru_seq_ctrl.sv - Sequencer feeding one sample per timestep into a combinational recurrent cell
// Holds the hidden state, captures the settled cell output and returns the final state per sequence.
module gru_seq_ctrl #(
    parameter int SEQ_LEN    = 16,
    parameter int IDX_W      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic [7:0]       x_data,
    input  logic             x_last,
    output logic             x_ready,
    output logic [7:0]       cell_x,
    output logic [7:0]       cell_h,
    input  logic [7:0]       cell_h_out,
    output logic             step_valid,
    output logic [7:0]       step_h,
    output logic [IDX_W-1:0] step_idx,
    output logic             res_valid,
    output logic [7:0]       res_data,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       h_reg;
    logic [IDX_W-1:0] step_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             last_q;
    logic             accept;
    logic             res_take;
    logic             settled;

    assign x_ready  = (state == IDLE) && !rst;
    assign accept   = x_valid && x_ready;
    assign res_take = res_valid && res_ready;
    assign settled  = (settle_cnt == '0);
    assign cell_h   = h_reg;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = SETTLE;
            SETTLE:  if (settled)  state_nxt = last_q ? DONE : IDLE;
            DONE:    if (res_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg      <= '0;
            cell_x     <= '0;
            step_cnt   <= '0;
            settle_cnt <= '0;
            last_q     <= 1'b0;
            step_valid <= 1'b0;
            step_h     <= '0;
            step_idx   <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            step_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cell_x     <= x_data;
                        // Forcing last on the SEQ_LEN-th sample keeps step_cnt from wrapping.
                        last_q     <= x_last || (step_cnt == LAST_IDX);
                        settle_cnt <= SET_INIT;
                    end
                end
                SETTLE: begin
                    if (settled) begin
                        h_reg      <= cell_h_out;
                        step_h     <= cell_h_out;
                        step_idx   <= step_cnt;
                        step_valid <= 1'b1;
                        if (last_q) begin
                            res_data  <= cell_h_out;
                            res_valid <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Hidden state restarts from zero for the next sequence.
                    if (res_take) begin
                        res_valid <= 1'b0;
                        h_reg     <= '0;
                        step_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// tb/tb_gru_seq_ctrl.sv - Directed self-checking bench for gru_seq_ctrl with an adder cell stub
module tb_gru_seq_ctrl;

    localparam int SEQ_LEN    = 4;
    localparam int IDX_W      = 2;
    localparam int SETTLE_CYC = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             x_valid = 1'b0;
    logic [7:0]       x_data = '0;
    logic             x_last = 1'b0;
    logic             x_ready;
    logic [7:0]       cell_x;
    logic [7:0]       cell_h;
    logic [7:0]       cell_h_out;
    logic             step_valid;
    logic [7:0]       step_h;
    logic [IDX_W-1:0] step_idx;
    logic             res_valid;
    logic [7:0]       res_data;
    logic             res_ready = 1'b0;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    gru_seq_ctrl #(.SEQ_LEN(SEQ_LEN), .IDX_W(IDX_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst(rst),
        .x_valid(x_valid), .x_data(x_data), .x_last(x_last), .x_ready(x_ready),
        .cell_x(cell_x), .cell_h(cell_h), .cell_h_out(cell_h_out),
        .step_valid(step_valid), .step_h(step_h), .step_idx(step_idx),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy)
    );

    assign cell_h_out = cell_x + cell_h;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers one sample, then follows it to its step_valid pulse and checks the capture.
    task automatic do_step(input logic [7:0] d, input logic l, input logic [7:0] exp_h,
                           input int exp_idx, input logic exp_res, input string tag);
        int n;
        int acc;
        @(negedge clk);
        x_data = d; x_last = l; x_valid = 1'b1;
        n = 0;
        while (!x_ready && n < 50) begin @(negedge clk); n++; end
        check_val({tag, " accept"}, 32'(x_ready), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        x_valid = 1'b0; x_last = 1'b0;
        @(negedge clk);
        n = 0;
        while (!step_valid && n < 20) begin @(negedge clk); n++; end
        check_val({tag, " step_valid"}, 32'(step_valid), 32'd1);
        check_val({tag, " step_h"}, 32'(step_h), 32'(exp_h));
        check_val({tag, " step_idx"}, 32'(step_idx), 32'(exp_idx));
        check_val({tag, " res_valid"}, 32'(res_valid), 32'(exp_res));
        if (exp_res) check_val({tag, " res_data"}, 32'(res_data), 32'(exp_h));
        @(negedge clk);
        check_val({tag, " step_valid fall"}, 32'(step_valid), 32'd0);
        check_val({tag, " fall latency"}, 32'(cyc - acc), 32'd3);
    endtask

    task automatic take_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int flag;
        // Reset held three cycles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("x_ready in reset", 32'(x_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("rst x_ready", 32'(x_ready), 32'd1);
        check_val("rst cell_x", 32'(cell_x), 32'd0);
        check_val("rst cell_h", 32'(cell_h), 32'd0);
        check_val("rst step_valid", 32'(step_valid), 32'd0);
        check_val("rst step_h", 32'(step_h), 32'd0);
        check_val("rst step_idx", 32'(step_idx), 32'd0);
        check_val("rst res_valid", 32'(res_valid), 32'd0);
        check_val("rst res_data", 32'(res_data), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);

        // Three-step sequence
        do_step(8'h10, 1'b0, 8'h10, 0, 1'b0, "seq3 s0");
        do_step(8'h20, 1'b0, 8'h30, 1, 1'b0, "seq3 s1");
        do_step(8'h05, 1'b1, 8'h35, 2, 1'b1, "seq3 s2");

        // Result backpressure
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp res_valid", 32'(res_valid), 32'd1);
            check_val("bp res_data", 32'(res_data), 32'h35);
            check_val("bp x_ready", 32'(x_ready), 32'd0);
            check_val("bp busy", 32'(busy), 32'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("release res_valid", 32'(res_valid), 32'd0);
        check_val("release cell_h", 32'(cell_h), 32'd0);
        check_val("release x_ready", 32'(x_ready), 32'd1);

        // SEQ_LEN limit without x_last
        do_step(8'h01, 1'b0, 8'h01, 0, 1'b0, "len s0");
        do_step(8'h02, 1'b0, 8'h03, 1, 1'b0, "len s1");
        do_step(8'h03, 1'b0, 8'h06, 2, 1'b0, "len s2");
        do_step(8'h04, 1'b0, 8'h0A, 3, 1'b1, "len s3");
        take_result();
        do_step(8'h05, 1'b0, 8'h05, 0, 1'b0, "len s4 new seq");

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst2 cell_h", 32'(cell_h), 32'd0);

        // Signed wrap, no saturation
        do_step(8'h7F, 1'b0, 8'h7F, 0, 1'b0, "wrap s0");
        do_step(8'h01, 1'b1, 8'h80, 1, 1'b1, "wrap s1");
        take_result();

        // Reset during SETTLE of step 1
        do_step(8'h11, 1'b0, 8'h11, 0, 1'b0, "mid s0");
        @(negedge clk);
        x_data = 8'h33; x_last = 1'b1; x_valid = 1'b1;
        check_val("mid accept", 32'(x_ready), 32'd1);
        @(posedge clk);
        #1;
        x_valid = 1'b0; x_last = 1'b0;
        @(negedge clk);
        check_val("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flag = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (step_valid || res_valid) flag = 1;
        end
        check_val("mid no pulse", 32'(flag), 32'd0);
        check_val("mid cell_h", 32'(cell_h), 32'd0);
        do_step(8'h22, 1'b1, 8'h22, 0, 1'b1, "after rst");
        take_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gru_seq_ctrl.md
Name: gru_seq_ctrl

Overview:
- Upstream sequencer for the combinational recurrent cell (8-bit X, h_in, h_out).
- Accepts a stream of 8-bit signed input samples over a valid/ready handshake and drives them onto the cell's X input one timestep at a time.
- Holds the hidden state in a register, feeds it back to the cell's h_in, and captures the cell's h_out once it has settled.
- Emits each per-step hidden state and the final hidden state of every sequence; the final state is returned over its own valid/ready handshake.

Parameters:
- SEQ_LEN, 16: maximum timesteps per sequence; range 1..2^IDX_W.
- IDX_W, 4: width of the step index.
- SETTLE_CYC, 2: cycles allowed for the cell's combinational path to settle before capture; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- x_valid  in  1  input sample valid.
- x_data  in  8  signed input sample.
- x_last  in  1  marks the final sample of a sequence; sampled with x_data.
- x_ready  out  1  controller can accept a sample.
- cell_x  out  8  to cell X.
- cell_h  out  8  to cell h_in; equals the hidden-state register.
- cell_h_out  in  8  from cell h_out.
- step_valid  out  1  one-cycle pulse when a new hidden state is captured.
- step_h  out  8  captured hidden state; valid with step_valid.
- step_idx  out  IDX_W  timestep index of the capture, starting at 0.
- res_valid  out  1  final hidden state available.
- res_data  out  8  final hidden state.
- res_ready  in  1  consumer accepts res_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clock edge): all of the following are cleared to 0, taking effect on the next cycle:
  - state returns to IDLE;
  - hidden-state register, cell_x, step counter, settle counter, step_h, step_idx, res_data;
  - step_valid, res_valid, busy.
- Reset mid-operation abandons the sequence. No res_valid is produced for it.
- x_ready = (state==IDLE) && !rst.
- States:
  - IDLE: waits for a sample.
    - On x_valid&&x_ready: cell_x<=x_data, last_q<=x_last||(step_cnt==SEQ_LEN-1), settle counter<=SETTLE_CYC-1, go to SETTLE.
  - SETTLE: cell_x and cell_h are held stable.
    - When the settle counter is 0: h_reg<=cell_h_out, step_h<=cell_h_out, step_idx<=step_cnt, step_valid<=1 for exactly one cycle.
    - Then, if last_q: res_data<=cell_h_out, res_valid<=1, go to DONE.
    - Otherwise: step_cnt<=step_cnt+1, go to IDLE.
    - Else: decrement the settle counter.
  - DONE: res_valid and res_data are held until res_valid&&res_ready.
    - On that edge: res_valid<=0, h_reg<=0, step_cnt<=0, go to IDLE.
    - x_ready is low throughout DONE.
- Timing: the capture edge is exactly SETTLE_CYC edges after the accept edge. step_valid is high in the cycle following the capture edge.
- The earliest next accept is the capture edge +1, so per-step throughput is one sample per SETTLE_CYC+1 cycles.
- Sequence length:
  - the sequence ends on x_last or on the SEQ_LEN-th sample, whichever comes first;
  - x_last on step 0 yields a one-step sequence;
  - step_cnt never exceeds SEQ_LEN-1; there is no wrap-around.
- Hidden state starts at 0 for every sequence. There is no carry-over between sequences.
- Arithmetic: the block does no arithmetic on data; values pass through as 8-bit two's complement. The step counter is unsigned IDX_W bits.
- res_ready while res_valid=0 is ignored.
- x_valid while x_ready=0 is ignored. The upstream source holds its data until it is accepted.
- step_valid and res_valid can rise in the same cycle, on the final step.

Test Plan:
- For all scenarios, the bench stubs the cell as cell_h_out=cell_x+cell_h (8-bit wrap).
- Reset then idle: after rst, every output is 0 and x_ready=1. Holding rst=1 for 3 cycles keeps x_ready=0.
- Three-step sequence (SETTLE_CYC=2), samples 0x10, 0x20, 0x05 with x_last on the third:
  - step_h = 0x10, 0x30, 0x35 at step_idx 0, 1, 2;
  - res_valid with res_data=0x35;
  - each step_valid falls exactly 3 cycles after its accept.
- Result backpressure: hold res_ready=0 for 5 cycles.
  - res_valid and res_data stay 0x35; x_ready stays 0.
  - Raise res_ready: one cycle later res_valid=0, cell_h=0x00, x_ready=1.
- SEQ_LEN limit (SEQ_LEN=4, x_last never asserted), samples 1, 2, 3, 4, 5:
  - res_data=0x0A after the 4th sample;
  - the 5th sample starts a new sequence, giving step_h=0x05 with step_idx=0.
- Signed wrap: samples 0x7F then 0x01 with x_last gives step_h=0x7F, then 0x80. No saturation.
- Reset mid-sequence: assert rst during SETTLE of step 1.
  - No step_valid or res_valid follows.
  - Next sequence with sample 0x22 and x_last gives res_data=0x22 and step_idx=0.
